// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with 2-FF input sync and mid-bit oversampling.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_error.
module uart_rx_8n1 #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       data_enable,
    output logic [7:0] uart_data,
    output logic       frame_error,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error,
`endif
    output logic       busy
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;

    logic [2:0]    state;
    logic          rx_m;
    logic          rx_s;
    logic [DW-1:0] div_cnt;
    logic [SW-1:0] smp_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          brk;
    logic          tick;
    logic          smp_last;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`endif

    assign tick     = (div_cnt == DIV_LAST);
    assign smp_last = tick && (smp_cnt == SMP_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            div_cnt     <= '0;
            smp_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            brk         <= 1'b0;
            data_enable <= 1'b0;
            frame_error <= 1'b0;
            uart_data   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
            par_bad      <= 1'b0;
`endif
        end else begin
            rx_m        <= rx;
            rx_s        <= rx_m;
            data_enable <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
            if (state != IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick)
                    smp_cnt <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    smp_cnt <= '0;
                    bit_cnt <= '0;
                    if (rx_s)
                        brk <= 1'b0;
                    else if (!brk)
                        state <= START;
                end
                START: begin
                    // Re-zero at mid start bit so later samples land mid-bit
                    if (tick && smp_cnt == SMP_MID) begin
                        smp_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (smp_last) begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (smp_last) begin
                        par_bad <= ^{shift, rx_s};
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is seen
                    if (smp_last) begin
                        state <= IDLE;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_error <= 1'b1;
                            end else begin
                                data_enable <= 1'b1;
                                uart_data   <= shift;
                            end
`else
                            data_enable <= 1'b1;
                            uart_data   <= shift;
`endif
                        end else begin
                            frame_error <= 1'b1;
                            brk         <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
